// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: snoops core stores into a byte FIFO and
// serialises them on Tx; exposes a combinational status word for loads.
module mmio_uart_tx #(
   parameter logic [31:0] BASE_ADDR    = 32'h0000_1000,
   parameter int          CLKS_PER_BIT = 16,
   parameter int          FIFO_DEPTH   = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        MemWrite,
   input  logic [31:0] DataAdr,
   input  logic [31:0] WriteData,
   output logic        UartSel,
   output logic [31:0] UartReadData,
   output logic        Tx
);

   localparam int BW = $clog2(CLKS_PER_BIT);
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;
   localparam logic [BW-1:0] BAUD_MAX = BW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] CNT_FULL = CW'(FIFO_DEPTH);

   typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

   logic [7:0]    r_mem [FIFO_DEPTH];
   logic [PW-1:0] r_wp, r_rp;
   logic [CW-1:0] r_cnt;
   logic          r_ovf;
   state_t        r_state;
   logic [BW-1:0] r_baud;
   logic [2:0]    r_bit;
   logic [7:0]    r_shift;
   logic          r_tx;

   logic          w_full, w_empty, w_busy;
   logic          w_wr_data, w_wr_stat, w_push, w_pop, w_baud_done;
   state_t        w_state_nxt;
   logic [BW-1:0] w_baud_nxt;
   logic [2:0]    w_bit_nxt;
   logic [7:0]    w_shift_nxt;
   logic          w_tx_nxt;
   logic [31:0]   w_status;
   logic          w_unused;

   assign UartSel   = (DataAdr[31:3] == BASE_ADDR[31:3]);
   assign w_wr_data = MemWrite && UartSel && !DataAdr[2];
   assign w_wr_stat = MemWrite && UartSel &&  DataAdr[2];

   assign w_full  = (r_cnt == CNT_FULL);
   assign w_empty = (r_cnt == '0);
   assign w_busy  = (r_state != S_IDLE);
   // Full is sampled before any same-cycle pop, so a write into a full FIFO is
   // always dropped even if the FSM frees a slot on that edge.
   assign w_push  = w_wr_data && !w_full;

   assign w_status     = {28'b0, r_ovf, w_busy, w_empty, w_full};
   assign UartReadData = (UartSel && DataAdr[2]) ? w_status : 32'b0;
   assign Tx           = r_tx;
   assign w_unused     = &{1'b0, WriteData[31:8], DataAdr[1:0]};

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wp] <= WriteData[7:0];
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_wp  <= '0;
         r_rp  <= '0;
         r_cnt <= '0;
         r_ovf <= 1'b0;
      end else begin
         if (w_push) r_wp <= r_wp + PW'(1);
         if (w_pop)  r_rp <= r_rp + PW'(1);
         case ({w_push, w_pop})
            2'b10:   r_cnt <= r_cnt + CW'(1);
            2'b01:   r_cnt <= r_cnt - CW'(1);
            default: r_cnt <= r_cnt;
         endcase
         if (w_wr_data && w_full)
            r_ovf <= 1'b1;
         else if (w_wr_stat && WriteData[3])
            r_ovf <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= S_IDLE;
         r_baud  <= '0;
         r_bit   <= '0;
         r_shift <= '0;
         r_tx    <= 1'b1;
      end else begin
         r_state <= w_state_nxt;
         r_baud  <= w_baud_nxt;
         r_bit   <= w_bit_nxt;
         r_shift <= w_shift_nxt;
         r_tx    <= w_tx_nxt;
      end
   end

   assign w_baud_done = (r_baud == BAUD_MAX);

   always_comb begin
      w_state_nxt = r_state;
      w_baud_nxt  = r_baud + BW'(1);
      w_bit_nxt   = r_bit;
      w_shift_nxt = r_shift;
      w_pop       = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_baud_nxt = '0;
            if (!w_empty) begin
               w_pop       = 1'b1;
               w_shift_nxt = r_mem[r_rp];
               w_state_nxt = S_START;
            end
         end
         S_START: begin
            if (w_baud_done) begin
               w_baud_nxt  = '0;
               w_bit_nxt   = '0;
               w_state_nxt = S_DATA;
            end
         end
         S_DATA: begin
            if (w_baud_done) begin
               w_baud_nxt  = '0;
               w_shift_nxt = r_shift >> 1;
               if (r_bit == 3'd7)
                  w_state_nxt = S_STOP;
               else
                  w_bit_nxt = r_bit + 3'd1;
            end
         end
         S_STOP: begin
            if (w_baud_done) begin
               w_baud_nxt = '0;
               // Chain straight into the next start bit when data is waiting.
               if (!w_empty) begin
                  w_pop       = 1'b1;
                  w_shift_nxt = r_mem[r_rp];
                  w_state_nxt = S_START;
               end else begin
                  w_state_nxt = S_IDLE;
               end
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Tx is registered from the next state so the pin only moves on clk edges.
   always_comb begin
      w_tx_nxt = 1'b1;
      case (w_state_nxt)
         S_START: w_tx_nxt = 1'b0;
         S_DATA:  w_tx_nxt = w_shift_nxt[0];
         default: w_tx_nxt = 1'b1;
      endcase
   end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Directed bench for mmio_uart_tx: reset, single frame timing, burst/overflow,
// decode, mid-frame reset and FIFO pointer wrap via a serial monitor.
module tb_mmio_uart_tx;

   localparam logic [31:0] BASE = 32'h0000_1000;
   localparam int          CPB  = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic        MemWrite;
   logic [31:0] DataAdr;
   logic [31:0] WriteData;
   logic        UartSel;
   logic [31:0] UartReadData;
   logic        Tx;

   int   npass  = 0;
   int   nfail  = 0;
   int   ntotal = 0;

   logic [7:0] rx_q [$];
   time        rx_t [$];
   int         stop_err = 0;
   bit         mon_en   = 1'b0;
   logic       mon_prev = 1'b1;
   logic       low_seen;
   logic [7:0] pat [10] = '{8'h00, 8'hFF, 8'h81, 8'h7E, 8'h3C,
                            8'hC3, 8'h55, 8'hAA, 8'h0F, 8'hF0};

   mmio_uart_tx #(
      .BASE_ADDR   (BASE),
      .CLKS_PER_BIT(CPB),
      .FIFO_DEPTH  (4)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .MemWrite    (MemWrite),
      .DataAdr     (DataAdr),
      .WriteData   (WriteData),
      .UartSel     (UartSel),
      .UartReadData(UartReadData),
      .Tx          (Tx)
   );

   always #5 clk = ~clk;

   // Serial monitor: samples each bit mid-cell on falling clk edges.
   always begin
      @(negedge clk);
      if (mon_en && Tx === 1'b0 && mon_prev === 1'b1) begin : frame
         logic [7:0] b;
         time        t0;
         t0 = $time;
         b  = '0;
         repeat (CPB + 1) @(negedge clk);
         for (int j = 0; j < 8; j++) begin
            b[j] = Tx;
            if (j < 7) repeat (CPB) @(negedge clk);
         end
         repeat (CPB) @(negedge clk);
         if (Tx !== 1'b1) stop_err++;
         repeat (2) @(negedge clk);
         rx_q.push_back(b);
         rx_t.push_back(t0);
      end
      mon_prev = Tx;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      ntotal++;
      assert (obs === exp) npass++;
      else begin
         nfail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d);
      DataAdr   = a;
      WriteData = d;
      MemWrite  = 1'b1;
      tick();
      MemWrite  = 1'b0;
   endtask

   task automatic rd_stat(input string tag, input logic [31:0] exp);
      DataAdr = BASE + 32'd4;
      #1;
      chk(tag, UartReadData, exp);
   endtask

   task automatic frame_check(input string tag, input logic [7:0] b);
      logic [9:0] f;
      f = {1'b1, b, 1'b0};
      for (int k = 0; k < 10 * CPB; k++) begin
         chk($sformatf("%s_cyc%0d", tag, k), {31'b0, Tx}, {31'b0, f[k / CPB]});
         tick();
      end
   endtask

   function automatic logic [31:0] rx_at(input int i);
      return (i < rx_q.size()) ? {24'b0, rx_q[i]} : 32'hxxxx_xxxx;
   endfunction

   initial begin
      reset     = 1'b0;
      MemWrite  = 1'b0;
      DataAdr   = BASE;
      WriteData = 32'h0000_00AA;
      #1;
      for (int i = 0; i < 3; i++) begin
         MemWrite = 1'b1;
         tick();
         MemWrite = 1'b0;
         #2;
      end
      chk("reset_tx", {31'b0, Tx}, 32'd1);
      DataAdr = BASE;
      #1;
      chk("reset_rd_txdata", UartReadData, 32'h0);
      rd_stat("reset_status", 32'h2);
      reset  = 1'b1;
      mon_en = 1'b1;
      low_seen = 1'b0;
      repeat (60) begin
         tick();
         if (Tx !== 1'b1) low_seen = 1'b1;
      end
      chk("reset_no_frame_tx", {31'b0, low_seen}, 32'd0);
      chk("reset_no_frame_rx", rx_q.size(), 32'd0);

      // Single byte with exact bit-cell timing
      wr(BASE, 32'hFFFF_FFA5);
      chk("sb_tx_e0", {31'b0, Tx}, 32'd1);
      rd_stat("sb_stat_e0", 32'h0);
      tick();
      rd_stat("sb_stat_e1", 32'h6);
      frame_check("sb", 8'hA5);
      rd_stat("sb_stat_end", 32'h2);
      chk("sb_tx_end", {31'b0, Tx}, 32'd1);
      chk("sb_mon", rx_at(0), 32'hA5);
      rx_q.delete();
      rx_t.delete();

      // Burst of six writes into a four-deep FIFO
      for (int i = 0; i < 6; i++) begin
         wr(BASE, 32'h11 + i);
         if (i == 4) rd_stat("burst_full", 32'h5);
         if (i == 5) rd_stat("burst_ovf", 32'hD);
      end
      repeat (210) tick();
      chk("burst_count", rx_q.size(), 32'd5);
      for (int i = 0; i < 5; i++)
         chk($sformatf("burst_byte%0d", i), rx_at(i), 32'h11 + i);
      for (int i = 1; i < 5; i++)
         chk($sformatf("burst_gap%0d", i),
             (i < rx_t.size()) ? 32'(rx_t[i] - rx_t[i-1]) : 32'hxxxx_xxxx,
             32'(10 * CPB * 10));
      rd_stat("burst_stat_end", 32'hA);
      rx_q.delete();
      rx_t.delete();

      // Decode: out-of-window and status writes never push
      wr(BASE + 32'd8, 32'h55);
      wr(BASE - 32'd4, 32'h55);
      wr(BASE + 32'd4, 32'h55);
      rd_stat("dec_stat", 32'hA);
      DataAdr = BASE + 32'd8;
      #1;
      chk("dec_sel_p8", {31'b0, UartSel}, 32'd0);
      chk("dec_rd_p8", UartReadData, 32'h0);
      DataAdr = BASE - 32'd4;
      #1;
      chk("dec_sel_m4", {31'b0, UartSel}, 32'd0);
      chk("dec_rd_m4", UartReadData, 32'h0);
      DataAdr = BASE;
      #1;
      chk("dec_sel_p0", {31'b0, UartSel}, 32'd1);
      chk("dec_rd_p0", UartReadData, 32'h0);
      DataAdr = BASE + 32'd7;
      #1;
      chk("dec_sel_p7", {31'b0, UartSel}, 32'd1);
      chk("dec_rd_p7", UartReadData, 32'hA);
      repeat (50) tick();
      chk("dec_no_frame", rx_q.size(), 32'd0);
      wr(BASE + 32'd4, 32'h8);
      rd_stat("ovf_clear", 32'h2);

      // Reset during data bit 3 with two bytes queued
      mon_en = 1'b0;
      wr(BASE, 32'hA5);
      wr(BASE, 32'h11);
      wr(BASE, 32'h22);
      repeat (16) tick();
      rd_stat("mid_stat", 32'h4);
      chk("mid_tx_bit3", {31'b0, Tx}, 32'd0);
      reset = 1'b0;
      #1;
      chk("mid_rst_tx", {31'b0, Tx}, 32'd1);
      rd_stat("mid_rst_stat", 32'h2);
      tick();
      tick();
      reset = 1'b1;
      rd_stat("mid_post_stat", 32'h2);
      low_seen = 1'b0;
      repeat (20) begin
         tick();
         if (Tx !== 1'b1) low_seen = 1'b1;
      end
      chk("mid_no_frame", {31'b0, low_seen}, 32'd0);
      wr(BASE, 32'h3C);
      tick();
      frame_check("post", 8'h3C);
      rd_stat("post_stat", 32'h2);

      // Ten isolated frames walk the pointers around the ring
      repeat (5) tick();
      rx_q.delete();
      rx_t.delete();
      mon_en = 1'b1;
      for (int i = 0; i < 10; i++) begin
         wr(BASE, 32'hDEAD_BE00 | {24'b0, pat[i]});
         repeat (42) tick();
      end
      chk("wrap_count", rx_q.size(), 32'd10);
      for (int i = 0; i < 10; i++)
         chk($sformatf("wrap_byte%0d", i), rx_at(i), {24'b0, pat[i]});
      chk("stop_bits", stop_err, 32'd0);
      rd_stat("final_stat", 32'h2);

      $display("%0d/%0d checks passed", npass, ntotal);
      $finish;
   end

endmodule
